mem_port_arbiter: RTL and testbench

- Shares the single memory port between two bus masters. Requester 0 is the CPU controller; requester 1 is a DMA or loader.
- Round-robin arbitration, one transaction in flight at a time.
- Drives the memory with the request/wait handshake: memory raises wait on accept and drops it when data is ready.
- Latches the winning master's command, returns read data, and signals done or timeout error per requester.

---
 rtl/mem_port_arbiter_if.sv | 57 +++++
 rtl/mem_port_arbiter.sv | 169 ++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 291 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_if.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter_if
// Bundles the two requester handshakes and the shared memory port of
// mem_port_arbiter.
//   master : arbiter view. It takes requests and memory status, and drives
//            grants, completion, read data and the memory command.
//   slave  : environment view. Requesters drive req/rwb/addr/wdata, and the
//            memory drives mem_wait/mem_rdata.
// Signals (per requester n = 0,1):
//   reqn, rwbn, addrn, wdatan : transaction request, direction, address, data
//   gntn, donen, errn         : grant level, completion pulse, timeout pulse
//   rdata                     : data of the last completed read
//   mem_req/rwb/addr/wdata    : memory command
//   mem_wait, mem_rdata       : memory busy flag and read data
// ---------------------------------------------------------------------------
interface mem_port_arbiter_if #(
    parameter int AW = 14,
    parameter int DW = 16
);
    logic          req0;
    logic          rwb0;
    logic [AW-1:0] addr0;
    logic [DW-1:0] wdata0;
    logic          req1;
    logic          rwb1;
    logic [AW-1:0] addr1;
    logic [DW-1:0] wdata1;
    logic          gnt0;
    logic          gnt1;
    logic          done0;
    logic          done1;
    logic          err0;
    logic          err1;
    logic [DW-1:0] rdata;
    logic          mem_req;
    logic          mem_rwb;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_wait;
    logic [DW-1:0] mem_rdata;

    modport master (
        input  req0, rwb0, addr0, wdata0,
        input  req1, rwb1, addr1, wdata1,
        input  mem_wait, mem_rdata,
        output gnt0, gnt1, done0, done1, err0, err1, rdata,
        output mem_req, mem_rwb, mem_addr, mem_wdata
    );

    modport slave (
        output req0, rwb0, addr0, wdata0,
        output req1, rwb1, addr1, wdata1,
        output mem_wait, mem_rdata,
        input  gnt0, gnt1, done0, done1, err0, err1, rdata,
        input  mem_req, mem_rwb, mem_addr, mem_wdata
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter
// Shares one memory port between requester 0 (CPU controller) and
// requester 1 (DMA/loader). The arbiter uses round-robin selection and allows
// one transaction in flight at a time. It uses the req/wait memory handshake:
// the memory raises mem_wait when it accepts a command and drops it when the
// data is ready. A phase that stalls for TIMEOUT cycles completes with err.
// Ports:
//   clk   : clock, rising edge
//   reset : asynchronous, active-high; aborts any transaction
//   bus   : mem_port_arbiter_if.master (requester handshakes + memory port)
// All outputs are registered and return to zero on reset.
// ---------------------------------------------------------------------------
module mem_port_arbiter #(
    parameter int AW      = 14,
    parameter int DW      = 16,
    parameter int TIMEOUT = 15,
    parameter int CW      = 4
) (
    input  logic               clk,
    input  logic               reset,
    mem_port_arbiter_if.master bus
);
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_ISSUE = 3'd1;
    localparam logic [2:0] S_BUSY  = 3'd2;
    localparam logic [2:0] S_DONE  = 3'd3;
    localparam logic [2:0] S_ERR   = 3'd4;

    localparam bit          TO_EN   = (TIMEOUT != 0);
    localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT - 1);

    logic [2:0]    r_state;
    logic [CW-1:0] r_cnt;
    logic          r_sel;
    logic          r_last;
    logic          r_gnt0;
    logic          r_gnt1;
    logic          r_done0;
    logic          r_done1;
    logic          r_err0;
    logic          r_err1;
    logic [DW-1:0] r_rdata;
    logic          r_mem_req;
    logic          r_mem_rwb;
    logic [AW-1:0] r_mem_addr;
    logic [DW-1:0] r_mem_wdata;

    logic          w_any;
    logic          w_pick;
    logic          w_timeout;
    logic [CW-1:0] w_cnt_inc;

    assign w_any     = bus.req0 | bus.req1;
    // With both requests pending, serve the one that was not served last.
    assign w_pick    = (bus.req0 & bus.req1) ? ~r_last : bus.req1;
    assign w_timeout = TO_EN && (r_cnt == TO_LAST);
    assign w_cnt_inc = (r_cnt == '1) ? r_cnt : r_cnt + 1'b1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_sel       <= 1'b0;
            r_last      <= 1'b1;
            r_gnt0      <= 1'b0;
            r_gnt1      <= 1'b0;
            r_done0     <= 1'b0;
            r_done1     <= 1'b0;
            r_err0      <= 1'b0;
            r_err1      <= 1'b0;
            r_rdata     <= '0;
            r_mem_req   <= 1'b0;
            r_mem_rwb   <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
        end else begin
            // done/err are single-cycle pulses by default.
            r_done0 <= 1'b0;
            r_done1 <= 1'b0;
            r_err0  <= 1'b0;
            r_err1  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_any) begin
                        r_sel       <= w_pick;
                        r_last      <= w_pick;
                        r_mem_rwb   <= w_pick ? bus.rwb1   : bus.rwb0;
                        r_mem_addr  <= w_pick ? bus.addr1  : bus.addr0;
                        r_mem_wdata <= w_pick ? bus.wdata1 : bus.wdata0;
                        r_gnt0      <= ~w_pick;
                        r_gnt1      <= w_pick;
                        r_mem_req   <= 1'b1;
                        r_cnt       <= '0;
                        r_state     <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (bus.mem_wait) begin
                        r_mem_req <= 1'b0;
                        r_cnt     <= '0;
                        r_state   <= S_BUSY;
                    end else if (w_timeout) begin
                        // The err/done pulse is raised on entry so it is
                        // visible during ERR. A requester dropping req on
                        // that pulse is then already low by the next IDLE.
                        r_mem_req <= 1'b0;
                        r_gnt0    <= 1'b0;
                        r_gnt1    <= 1'b0;
                        r_done0   <= ~r_sel;
                        r_done1   <= r_sel;
                        r_err0    <= ~r_sel;
                        r_err1    <= r_sel;
                        r_state   <= S_ERR;
                    end else begin
                        r_cnt <= w_cnt_inc;
                    end
                end
                S_BUSY: begin
                    if (!bus.mem_wait) begin
                        if (r_mem_rwb) begin
                            r_rdata <= bus.mem_rdata;
                        end
                        r_done0 <= ~r_sel;
                        r_done1 <= r_sel;
                        r_gnt0  <= 1'b0;
                        r_gnt1  <= 1'b0;
                        r_state <= S_DONE;
                    end else if (w_timeout) begin
                        r_mem_req <= 1'b0;
                        r_gnt0    <= 1'b0;
                        r_gnt1    <= 1'b0;
                        r_done0   <= ~r_sel;
                        r_done1   <= r_sel;
                        r_err0    <= ~r_sel;
                        r_err1    <= r_sel;
                        r_state   <= S_ERR;
                    end else begin
                        r_cnt <= w_cnt_inc;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                S_ERR: begin
                    r_mem_req <= 1'b0;
                    r_gnt0    <= 1'b0;
                    r_gnt1    <= 1'b0;
                    r_state   <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.gnt0      = r_gnt0;
    assign bus.gnt1      = r_gnt1;
    assign bus.done0     = r_done0;
    assign bus.done1     = r_done1;
    assign bus.err0      = r_err0;
    assign bus.err1      = r_err1;
    assign bus.rdata     = r_rdata;
    assign bus.mem_req   = r_mem_req;
    assign bus.mem_rwb   = r_mem_rwb;
    assign bus.mem_addr  = r_mem_addr;
    assign bus.mem_wdata = r_mem_wdata;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_port_arbiter
// Directed stimulus for mem_port_arbiter against a small memory model. The
// model raises mem_wait one cycle after it sees mem_req and returns
// addr+1 three cycles later. It can also ignore requests or hold wait high.
// Expected completions are queued when stimulus is issued. A monitor pops
// one entry each time done0/done1 is observed.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_mem_port_arbiter;
    localparam int AW      = 14;
    localparam int DW      = 16;
    localparam int TIMEOUT = 15;
    localparam int CW      = 4;

    typedef struct {
        int            id;
        logic          err;
        logic [DW-1:0] rdata;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    mem_port_arbiter_if #(.AW(AW), .DW(DW)) bus ();

    mem_port_arbiter #(
        .AW(AW), .DW(DW), .TIMEOUT(TIMEOUT), .CW(CW)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   m_mode = 0;   // 0 normal, 1 never raise wait, 2 hold wait high

    // Memory model: owns mem_wait / mem_rdata.
    initial begin : memory_model
        int            phase;
        int            cnt;
        logic [AW-1:0] a;
        phase = 0;
        cnt   = 0;
        a     = '0;
        bus.mem_wait  = 1'b0;
        bus.mem_rdata = '0;
        forever begin
            @(posedge clk);
            #2;
            case (phase)
                0: if (bus.mem_req && m_mode != 1) begin
                       a     = bus.mem_addr;
                       phase = 1;
                   end
                1: begin
                       bus.mem_wait = 1'b1;
                       cnt   = 0;
                       phase = 2;
                   end
                default: begin
                       cnt++;
                       if (m_mode == 0 && cnt >= 3) begin
                           bus.mem_wait  = 1'b0;
                           bus.mem_rdata = DW'(a) + DW'(1);
                           phase = 0;
                       end
                   end
            endcase
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int id, input logic err, input logic [DW-1:0] rd);
        exp_t e;
        e.id    = id;
        e.err   = err;
        e.rdata = rd;
        sb.push_back(e);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_ctl"}, 32'({bus.gnt0, bus.gnt1, bus.done0, bus.done1,
                                bus.err0, bus.err1, bus.mem_req, bus.mem_rwb}), 32'd0);
        chk({tag, "_addr"},  32'(bus.mem_addr),  32'd0);
        chk({tag, "_wdata"}, 32'(bus.mem_wdata), 32'd0);
        chk({tag, "_rdata"}, 32'(bus.rdata),     32'd0);
    endtask

    // Waits for a done pulse. It counts the sampled cycles and the cycles with
    // mem_req high, and notes gnt1 activity. With wchk set, it also checks that
    // the write command held on the memory port while gnt1 is high.
    task automatic wait_done(output int id, output int cyc, output int reqc,
                             output bit g1, output bit bad, input bit wchk,
                             input logic [AW-1:0] waddr, input logic [DW-1:0] wdat);
        id = -1; cyc = 0; reqc = 0; g1 = 1'b0; bad = 1'b0;
        for (int n = 0; n < 200; n++) begin
            tick();
            cyc++;
            if (bus.done0 || bus.done1) begin
                id = bus.done1 ? 1 : 0;
                return;
            end
            if (bus.mem_req) reqc++;
            if (bus.gnt1) g1 = 1'b1;
            if (wchk && bus.gnt1 && (bus.mem_rwb !== 1'b0 || bus.mem_addr !== waddr ||
                                     bus.mem_wdata !== wdat)) bad = 1'b1;
        end
        checks++;
        errors++;
        $display("FAIL wait_done got=no done exp=done within 200 cycles");
    endtask

    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge clk);
            if (reset !== 1'b1) begin
                chk("gnt_excl", 32'(bus.gnt0 & bus.gnt1), 32'd0);
                chk("err_wo_done", 32'((bus.err0 & ~bus.done0) | (bus.err1 & ~bus.done1)), 32'd0);
                if (bus.done0 || bus.done1) begin
                    chk("done_excl", 32'(bus.done0 & bus.done1), 32'd0);
                    if (sb.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_done got=done0:%0b done1:%0b exp=no done",
                                 bus.done0, bus.done1);
                    end else begin
                        e = sb.pop_front();
                        chk("sb_done_id", 32'(bus.done1), 32'(e.id));
                        chk("sb_err", 32'(bus.done1 ? bus.err1 : bus.err0), 32'(e.err));
                        chk("sb_rdata", 32'(bus.rdata), 32'(e.rdata));
                    end
                end
            end
        end
    endtask

    task automatic stimulus();
        int id, cyc, reqc;
        bit g1, bad, found;
        reset = 1'b1;
        bus.req0 = 1'b0; bus.rwb0 = 1'b0; bus.addr0 = '0; bus.wdata0 = '0;
        bus.req1 = 1'b0; bus.rwb1 = 1'b0; bus.addr1 = '0; bus.wdata1 = '0;
        #1;
        check_zero("reset");
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;

        // Single read from requester 0
        tick();
        bus.req0 = 1'b1; bus.rwb0 = 1'b1; bus.addr0 = 14'h0002;
        push(0, 1'b0, 16'h0003);
        chk("t1_req_pre", 32'(bus.mem_req), 32'd0);
        tick();
        chk("t1_mem_req", 32'(bus.mem_req), 32'd1);
        chk("t1_mem_addr", 32'(bus.mem_addr), 32'h2);
        chk("t1_gnt0", 32'(bus.gnt0), 32'd1);
        chk("t1_mem_rwb", 32'(bus.mem_rwb), 32'd1);
        wait_done(id, cyc, reqc, g1, bad, 1'b0, '0, '0);
        chk("t1_id", 32'(id), 32'd0);
        chk("t1_latency", 32'(cyc), 32'd5);
        chk("t1_gnt1_never", 32'(g1), 32'd0);
        tick();
        bus.req0 = 1'b0;

        // Write from requester 1; rdata must stay at 3
        bus.req1 = 1'b1; bus.rwb1 = 1'b0; bus.addr1 = 14'h0005; bus.wdata1 = 16'hBEEF;
        push(1, 1'b0, 16'h0003);
        wait_done(id, cyc, reqc, g1, bad, 1'b1, 14'h0005, 16'hBEEF);
        chk("t2_id", 32'(id), 32'd1);
        chk("t2_gnt1_seen", 32'(g1), 32'd1);
        chk("t2_wr_hold", 32'(bad), 32'd0);
        tick();
        bus.req1 = 1'b0;

        // Both requesting: strict alternation 0,1,0,1
        bus.req0 = 1'b1; bus.rwb0 = 1'b1; bus.addr0 = 14'h0001;
        bus.req1 = 1'b1; bus.rwb1 = 1'b1; bus.addr1 = 14'h0003;
        push(0, 1'b0, 16'h0002); push(1, 1'b0, 16'h0004);
        push(0, 1'b0, 16'h0002); push(1, 1'b0, 16'h0004);
        for (int k = 0; k < 4; k++) begin
            wait_done(id, cyc, reqc, g1, bad, 1'b0, '0, '0);
            chk("t3_order", 32'(id), 32'(k % 2));
            tick();
            if (k == 2) bus.req0 = 1'b0;
            if (k == 3) bus.req1 = 1'b0;
        end

        // Timeout in ISSUE, then pending requester 1 is served
        m_mode = 1;
        bus.req0 = 1'b1; bus.rwb0 = 1'b1; bus.addr0 = 14'h0002;
        bus.req1 = 1'b1; bus.rwb1 = 1'b1; bus.addr1 = 14'h0007;
        push(0, 1'b1, 16'h0004); push(1, 1'b0, 16'h0008);
        wait_done(id, cyc, reqc, g1, bad, 1'b0, '0, '0);
        chk("t4_id", 32'(id), 32'd0);
        chk("t4_cycles", 32'(cyc), 32'd16);
        chk("t4_issue_cycles", 32'(reqc), 32'd15);
        chk("t4_mem_req_at_err", 32'(bus.mem_req), 32'd0);
        chk("t4_err0", 32'(bus.err0), 32'd1);
        m_mode = 0;
        tick();
        bus.req0 = 1'b0;
        wait_done(id, cyc, reqc, g1, bad, 1'b0, '0, '0);
        chk("t4_next_id", 32'(id), 32'd1);
        tick();
        bus.req1 = 1'b0;

        // Stuck memory in BUSY; rdata held at 8
        m_mode = 2;
        bus.req0 = 1'b1; bus.rwb0 = 1'b1; bus.addr0 = 14'h0009;
        push(0, 1'b1, 16'h0008);
        wait_done(id, cyc, reqc, g1, bad, 1'b0, '0, '0);
        chk("t5_id", 32'(id), 32'd0);
        chk("t5_cycles", 32'(cyc), 32'd18);
        chk("t5_err0", 32'(bus.err0), 32'd1);
        m_mode = 0;
        tick();
        bus.req0 = 1'b0;
        tick();
        tick();
        chk("t5_idle", 32'({bus.gnt0, bus.gnt1, bus.mem_req}), 32'd0);

        // Reset mid-BUSY. The pointer favours 1 until reset restores it.
        m_mode = 2;
        bus.req0 = 1'b1; bus.rwb0 = 1'b1; bus.addr0 = 14'h0004;
        found = 1'b0;
        for (int n = 0; n < 50 && !found; n++) begin
            tick();
            if (bus.gnt0 && !bus.mem_req && bus.mem_wait) found = 1'b1;
        end
        chk("t6_reached_busy", 32'(found), 32'd1);
        tick();
        tick();
        #3;
        reset = 1'b1;
        #1;
        check_zero("t6_async");
        bus.req0 = 1'b0;
        m_mode = 0;
        repeat (2) tick();
        bus.req0 = 1'b1; bus.rwb0 = 1'b1; bus.addr0 = 14'h0001;
        bus.req1 = 1'b1; bus.rwb1 = 1'b1; bus.addr1 = 14'h0003;
        push(0, 1'b0, 16'h0002); push(1, 1'b0, 16'h0004);
        reset = 1'b0;
        tick();
        chk("t6_first_gnt0", 32'(bus.gnt0), 32'd1);
        chk("t6_first_gnt1", 32'(bus.gnt1), 32'd0);
        wait_done(id, cyc, reqc, g1, bad, 1'b0, '0, '0);
        chk("t6_id_a", 32'(id), 32'd0);
        tick();
        bus.req0 = 1'b0;
        wait_done(id, cyc, reqc, g1, bad, 1'b0, '0, '0);
        chk("t6_id_b", 32'(id), 32'd1);
        tick();
        bus.req1 = 1'b0;
        repeat (3) tick();
        chk("sb_empty", 32'(sb.size()), 32'd0);
    endtask

    initial begin
        fork
            monitor();
            stimulus();
            begin
                #400000;
                checks++;
                errors++;
                $display("FAIL watchdog got=still running exp=finished");
            end
        join_any
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
